// File: rtl/zcmt_jt_cache_pkg.sv
// Shared types for the Zcmt jump-table cache: core config subset, data-cache
// port structs, the JVT CSR layout and the cached jump-table entry.
package zcmt_jt_cache_pkg;

  localparam int unsigned DcacheIndexWidth = 12;
  localparam int unsigned DcacheTagWidth   = 22;
  localparam int unsigned DcacheTidWidth   = 2;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_TAG_WIDTH;
    int unsigned DCACHE_TID_WIDTH;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:               32,
    DCACHE_INDEX_WIDTH: DcacheIndexWidth,
    DCACHE_TAG_WIDTH:   DcacheTagWidth,
    DCACHE_TID_WIDTH:   DcacheTidWidth
  };

  localparam int unsigned ZcmtIndexWidth = 8;
  localparam int unsigned ZcmtEntryBytes = 4;

  typedef struct packed {
    logic                      valid;
    logic [ZcmtIndexWidth-1:0] tag;
    logic [31:0]               target;
  } zcmt_entry_t;

  typedef struct packed {
    logic [25:0] base;
    logic [5:0]  mode;
  } zcmt_jvt_t;

  typedef struct packed {
    logic [DcacheIndexWidth-1:0] address_index;
    logic [DcacheTagWidth-1:0]   address_tag;
    logic [31:0]                 data_wdata;
    logic [0:0]                  data_wuser;
    logic                        data_req;
    logic                        data_we;
    logic [3:0]                  data_be;
    logic [1:0]                  data_size;
    logic [DcacheTidWidth-1:0]   data_id;
    logic                        kill_req;
    logic                        tag_valid;
  } zcmt_dcache_req_i_t;

  typedef struct packed {
    logic                      data_gnt;
    logic                      data_rvalid;
    logic [DcacheTidWidth-1:0] data_rid;
    logic [31:0]               data_rdata;
  } zcmt_dcache_req_o_t;

  // Byte address of a jump-table slot; wraps modulo 2^32.
  function automatic logic [31:0] zcmt_entry_addr(input logic [31:0]               jvt_word,
                                                  input logic [ZcmtIndexWidth-1:0] index);
    return jvt_word + (32'(index) << $clog2(ZcmtEntryBytes));
  endfunction

endpackage

// File: rtl/zcmt_jt_cache_lzc.sv
// Leading/trailing zero counter; with MODE=0 it returns the position of the
// lowest set bit of in_i, empty_o flags an all-zero input.
module zcmt_jt_cache_lzc #(
  parameter  int unsigned WIDTH = 4,
  parameter  bit          MODE  = 1'b0,
  localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE) begin
      // Last assignment wins: highest set bit gives the leading-zero count.
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) cnt_o = CntW'(int'(WIDTH) - 1 - i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntW'(i);
      end
    end
  end

endmodule

// File: rtl/zcmt_jt_cache.sv
// Small fully associative cache of Zcmt jump-table entries; misses fetch the
// 32-bit target through a data-cache port, one fill outstanding at a time.
module zcmt_jt_cache
  import zcmt_jt_cache_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg        = cva6_cfg_empty,
  parameter type         dcache_req_i_t = zcmt_dcache_req_i_t,
  parameter type         dcache_req_o_t = zcmt_dcache_req_o_t,
  parameter type         jvt_t          = zcmt_jvt_t,
  parameter int unsigned NrEntries      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  jvt_t                      jvt_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ZcmtIndexWidth-1:0] index_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_target_o,
  input  dcache_req_o_t             req_port_i,
  output dcache_req_i_t             req_port_o
);

  localparam int unsigned IdxW = CVA6Cfg.DCACHE_INDEX_WIDTH;
  localparam int unsigned TagW = CVA6Cfg.DCACHE_TAG_WIDTH;
  localparam int unsigned TidW = CVA6Cfg.DCACHE_TID_WIDTH;
  localparam int unsigned PtrW = $clog2(NrEntries);

  if (CVA6Cfg.XLEN != 32) begin : gen_xlen_check
    $error("zcmt_jt_cache supports XLEN == 32 only");
  end
  if (NrEntries < 2 || NrEntries > 16 || (NrEntries & (NrEntries - 1)) != 0) begin : gen_entries_check
    $error("zcmt_jt_cache NrEntries must be a power of two in 2..16");
  end
  if (IdxW + TagW != 34) begin : gen_addr_check
    $error("zcmt_jt_cache expects index + tag widths to cover 34 address bits");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e                        state_q, state_d;
  zcmt_entry_t [NrEntries-1:0]   entry_q, entry_d;
  logic [PtrW-1:0]               rr_q, rr_d;
  logic [ZcmtIndexWidth-1:0]     idx_q, idx_d;
  logic [31:0]                   addr_q, addr_d;
  logic                          pend_q, pend_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [31:0]                   rsp_target_q, rsp_target_d;

  logic                          hit;
  logic [31:0]                   hit_target;
  logic [NrEntries-1:0]          free_vec;
  logic [PtrW-1:0]               free_idx;
  logic                          all_valid;
  logic [PtrW-1:0]               victim;
  logic                          rsp_match;
  logic                          data_req;
  logic                          fill;
  logic [33:0]                   addr_full;

  always_comb begin
    hit        = 1'b0;
    hit_target = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      free_vec[i] = ~entry_q[i].valid;
      if (entry_q[i].valid && entry_q[i].tag == index_i) begin
        hit        = 1'b1;
        hit_target = entry_q[i].target;
      end
    end
  end

  zcmt_jt_cache_lzc #(
    .WIDTH (NrEntries),
    .MODE  (1'b0)
  ) i_first_free (
    .in_i    (free_vec),
    .cnt_o   (free_idx),
    .empty_o (all_valid)
  );

  assign victim    = all_valid ? rr_q : free_idx;
  assign rsp_match = req_port_i.data_rvalid && (req_port_i.data_rid == TidW'(1));

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    rr_d         = rr_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    rsp_valid_d  = 1'b0;
    rsp_target_d = rsp_target_q;
    req_ready_o  = 1'b0;
    data_req     = 1'b0;
    fill         = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = ~flush_i;
        if (req_valid_i && !flush_i) begin
          if (hit) begin
            rsp_valid_d  = 1'b1;
            rsp_target_d = hit_target;
          end else begin
            // Address is frozen here so a JVT write during the fill cannot
            // move a request the cache has not granted yet.
            idx_d   = index_i;
            addr_d  = zcmt_entry_addr({jvt_i.base, jvt_i.mode}, index_i);
            state_d = REQ;
          end
        end
      end
      REQ: begin
        data_req = 1'b1;
        if (req_port_i.data_gnt) begin
          pend_d  = 1'b0;
          state_d = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          pend_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      WAIT: begin
        if (rsp_match) begin
          state_d = IDLE;
          if (!flush_i) begin
            fill         = 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_target_d = req_port_i.data_rdata;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A flushed request still completes its handshake, then its data is dropped.
        data_req = pend_q;
        if (pend_q) begin
          if (req_port_i.data_gnt) pend_d = 1'b0;
        end else if (rsp_match) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fill) begin
      entry_d[victim] = '{valid: 1'b1, tag: idx_q, target: req_port_i.data_rdata};
      if (all_valid) begin
        rr_d = (rr_q == PtrW'(NrEntries - 1)) ? '0 : rr_q + PtrW'(1);
      end
    end

    if (flush_i) begin
      for (int unsigned i = 0; i < NrEntries; i++) begin
        entry_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      rr_q         <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_target_q <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_target_q <= rsp_target_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_target_o = rsp_target_q;
  assign addr_full    = {2'b00, addr_q};

  always_comb begin
    req_port_o               = '0;
    req_port_o.address_index = addr_full[IdxW-1:0];
    req_port_o.address_tag   = addr_full[IdxW +: TagW];
    req_port_o.data_wdata    = '0;
    req_port_o.data_wuser    = '0;
    req_port_o.data_req      = data_req;
    req_port_o.data_we       = 1'b0;
    req_port_o.data_be       = 4'hF;
    req_port_o.data_size     = 2'b10;
    req_port_o.data_id       = TidW'(1);
    req_port_o.kill_req      = 1'b0;
    req_port_o.tag_valid     = 1'b1;
  end

endmodule

// File: tb/tb_zcmt_jt_cache.sv
// Directed bench for zcmt_jt_cache: table of lookups plus hand-written
// flush, foreign-rid, idle-rvalid and reset-mid-fill sequences.
module tb_zcmt_jt_cache;
  import zcmt_jt_cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               req_valid = 1'b0;
  logic [7:0]         index = 8'd0;
  zcmt_jvt_t          jvt;
  logic               req_ready;
  logic               rsp_valid;
  logic [31:0]        rsp_target;
  zcmt_dcache_req_o_t dc_rsp;
  zcmt_dcache_req_i_t dc_req;
  logic [33:0]        full_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          do_flush;
    logic [31:0] jvt;
    logic [7:0]  idx;
    logic [31:0] rdata;
    bit          exp_hit;
    logic [31:0] exp_addr;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  assign full_addr = {dc_req.address_tag, dc_req.address_index};

  zcmt_jt_cache #(
    .CVA6Cfg        (cva6_cfg_empty),
    .dcache_req_i_t (zcmt_dcache_req_i_t),
    .dcache_req_o_t (zcmt_dcache_req_o_t),
    .jvt_t          (zcmt_jvt_t),
    .NrEntries      (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .jvt_i        (jvt),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .index_i      (index),
    .rsp_valid_o  (rsp_valid),
    .rsp_target_o (rsp_target),
    .req_port_i   (dc_rsp),
    .req_port_o   (dc_req)
  );

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_flush(input logic [31:0] new_jvt);
    @(negedge clk);
    jvt   = zcmt_jvt_t'(new_jvt);
    flush = 1'b1;
    #1 chk_b("flush_rdy", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_lookup(input string nm, input logic [7:0] idx, input logic [31:0] rdata,
                           input bit exp_hit, input logic [31:0] exp_addr,
                           input logic [31:0] exp_tgt);
    @(negedge clk);
    req_valid = 1'b1;
    index     = idx;
    #1 chk_b({nm, "_rdy"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_hit) begin
      chk_b({nm, "_hit_vld"}, rsp_valid, 1'b1);
      chk_w({nm, "_hit_tgt"}, rsp_target, exp_tgt);
      chk_b({nm, "_hit_noreq"}, dc_req.data_req, 1'b0);
    end else begin
      chk_b({nm, "_miss_novld"}, rsp_valid, 1'b0);
      chk_b({nm, "_miss_req"}, dc_req.data_req, 1'b1);
      chk_w({nm, "_addr"}, full_addr[31:0], exp_addr);
      chk_b({nm, "_addr_hi"}, |full_addr[33:32], 1'b0);
      chk_w({nm, "_fields"},
            32'({dc_req.data_we, dc_req.data_be, dc_req.data_size, dc_req.data_id,
                 dc_req.kill_req, dc_req.tag_valid, dc_req.data_wuser}),
            32'({1'b0, 4'hF, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0}));
      chk_w({nm, "_wdata"}, dc_req.data_wdata, 32'h0);
      @(negedge clk);
      chk_b({nm, "_req_held"}, dc_req.data_req, 1'b1);
      chk_b({nm, "_busy"}, req_ready, 1'b0);
      dc_rsp.data_gnt = 1'b1;
      @(negedge clk);
      dc_rsp.data_gnt = 1'b0;
      chk_b({nm, "_req_drop"}, dc_req.data_req, 1'b0);
      dc_rsp.data_rvalid = 1'b1;
      dc_rsp.data_rid    = 2'd1;
      dc_rsp.data_rdata  = rdata;
      @(negedge clk);
      dc_rsp.data_rvalid = 1'b0;
      chk_b({nm, "_fill_vld"}, rsp_valid, 1'b1);
      chk_w({nm, "_fill_tgt"}, rsp_target, exp_tgt);
    end
    @(negedge clk);
    chk_b({nm, "_pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //               flush jvt           idx     rdata          hit   addr           target
    vecs[0]  = '{1'b1, 32'h0000_1000, 8'd5,   32'h0000_8000, 1'b0, 32'h0000_1014, 32'h0000_8000};
    vecs[1]  = '{1'b0, 32'h0000_1000, 8'd5,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_8000};
    vecs[2]  = '{1'b1, 32'h0000_1000, 8'd1,   32'hA000_0004, 1'b0, 32'h0000_1004, 32'hA000_0004};
    vecs[3]  = '{1'b0, 32'h0000_1000, 8'd2,   32'hA000_0008, 1'b0, 32'h0000_1008, 32'hA000_0008};
    vecs[4]  = '{1'b0, 32'h0000_1000, 8'd3,   32'hA000_000C, 1'b0, 32'h0000_100C, 32'hA000_000C};
    vecs[5]  = '{1'b0, 32'h0000_1000, 8'd4,   32'hA000_0010, 1'b0, 32'h0000_1010, 32'hA000_0010};
    vecs[6]  = '{1'b0, 32'h0000_1000, 8'd7,   32'hA000_001C, 1'b0, 32'h0000_101C, 32'hA000_001C};
    vecs[7]  = '{1'b0, 32'h0000_1000, 8'd2,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA000_0008};
    vecs[8]  = '{1'b0, 32'h0000_1000, 8'd3,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA000_000C};
    vecs[9]  = '{1'b0, 32'h0000_1000, 8'd4,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA000_0010};
    vecs[10] = '{1'b0, 32'h0000_1000, 8'd1,   32'hB000_0004, 1'b0, 32'h0000_1004, 32'hB000_0004};
    vecs[11] = '{1'b0, 32'h0000_1000, 8'd7,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA000_001C};
    vecs[12] = '{1'b0, 32'h0000_1000, 8'd2,   32'hB000_0008, 1'b0, 32'h0000_1008, 32'hB000_0008};
    vecs[13] = '{1'b0, 32'h0000_1000, 8'd255, 32'hC0DE_0000, 1'b0, 32'h0000_13FC, 32'hC0DE_0000};
    vecs[14] = '{1'b1, 32'hFFFF_FFC0, 8'd255, 32'h0BAD_F00D, 1'b0, 32'h0000_03BC, 32'h0BAD_F00D};

    jvt    = zcmt_jvt_t'(32'h0);
    dc_rsp = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_b("rst_rsp_vld", rsp_valid, 1'b0);
    chk_w("rst_rsp_tgt", rsp_target, 32'h0);
    chk_b("rst_data_req", dc_req.data_req, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("rst_rdy", req_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_flush) do_flush(vecs[i].jvt);
      do_lookup($sformatf("v%0d", i), vecs[i].idx, vecs[i].rdata, vecs[i].exp_hit,
                vecs[i].exp_addr, vecs[i].exp_tgt);
    end

    // Flush while waiting for rvalid: data dropped, entry refetched
    do_flush(32'h0000_1000);
    @(negedge clk);
    req_valid = 1'b1;
    index     = 8'd40;
    @(negedge clk);
    req_valid       = 1'b0;
    dc_rsp.data_gnt = 1'b1;
    @(negedge clk);
    dc_rsp.data_gnt = 1'b0;
    flush           = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_b("wflush_noreq", dc_req.data_req, 1'b0);
    chk_b("wflush_busy", req_ready, 1'b0);
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 2'd1;
    dc_rsp.data_rdata  = 32'hDEAD_0040;
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b0;
    chk_b("wflush_norsp", rsp_valid, 1'b0);
    chk_b("wflush_rdy", req_ready, 1'b1);
    do_lookup("wflush_reissue", 8'd40, 32'h4040_0000, 1'b0, 32'h0000_10A0, 32'h4040_0000);

    // Foreign rid ignored, matching rid two cycles later delivered
    @(negedge clk);
    req_valid = 1'b1;
    index     = 8'd41;
    @(negedge clk);
    req_valid       = 1'b0;
    dc_rsp.data_gnt = 1'b1;
    @(negedge clk);
    dc_rsp.data_gnt    = 1'b0;
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 2'd0;
    dc_rsp.data_rdata  = 32'hBAD0_0000;
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b0;
    chk_b("rid0_norsp", rsp_valid, 1'b0);
    chk_b("rid0_busy", req_ready, 1'b0);
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 2'd1;
    dc_rsp.data_rdata  = 32'h4141_0000;
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b0;
    chk_b("rid1_vld", rsp_valid, 1'b1);
    chk_w("rid1_tgt", rsp_target, 32'h4141_0000);
    @(negedge clk);
    chk_b("rid1_pulse", rsp_valid, 1'b0);
    do_lookup("rid1_hit", 8'd41, 32'h0, 1'b1, 32'h0, 32'h4141_0000);

    // Flush together with a request for a cached index
    do_lookup("sim_fill", 8'd5, 32'h0000_8000, 1'b0, 32'h0000_1014, 32'h0000_8000);
    do_lookup("sim_hit", 8'd5, 32'h0, 1'b1, 32'h0, 32'h0000_8000);
    @(negedge clk);
    req_valid = 1'b1;
    index     = 8'd5;
    flush     = 1'b1;
    #1 chk_b("sim_rdy", req_ready, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk_b("sim_norsp", rsp_valid, 1'b0);
    chk_b("sim_noreq", dc_req.data_req, 1'b0);
    do_lookup("sim_remiss", 8'd5, 32'h5555_0000, 1'b0, 32'h0000_1014, 32'h5555_0000);

    // Flush in REQ: request held until grant, fill discarded
    @(negedge clk);
    req_valid = 1'b1;
    index     = 8'd50;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_b("rflush_req_held", dc_req.data_req, 1'b1);
    chk_w("rflush_addr", full_addr[31:0], 32'h0000_10C8);
    dc_rsp.data_gnt = 1'b1;
    @(negedge clk);
    dc_rsp.data_gnt = 1'b0;
    chk_b("rflush_req_drop", dc_req.data_req, 1'b0);
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 2'd1;
    dc_rsp.data_rdata  = 32'h5050_0000;
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b0;
    chk_b("rflush_norsp", rsp_valid, 1'b0);
    chk_b("rflush_rdy", req_ready, 1'b1);
    do_lookup("rflush_remiss", 8'd5, 32'h5656_0000, 1'b0, 32'h0000_1014, 32'h5656_0000);

    // Stray rvalid in IDLE ignored
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b1;
    dc_rsp.data_rid    = 2'd1;
    dc_rsp.data_rdata  = 32'hEEEE_0000;
    @(negedge clk);
    dc_rsp.data_rvalid = 1'b0;
    chk_b("idle_rv_norsp", rsp_valid, 1'b0);
    chk_b("idle_rv_rdy", req_ready, 1'b1);
    do_lookup("idle_rv_hit", 8'd5, 32'h0, 1'b1, 32'h0, 32'h5656_0000);

    // Reset in the middle of a fill
    @(negedge clk);
    req_valid = 1'b1;
    index     = 8'd60;
    @(negedge clk);
    req_valid       = 1'b0;
    dc_rsp.data_gnt = 1'b1;
    @(negedge clk);
    dc_rsp.data_gnt = 1'b0;
    rst_n           = 1'b0;
    #1;
    chk_b("mrst_noreq", dc_req.data_req, 1'b0);
    chk_b("mrst_norsp", rsp_valid, 1'b0);
    chk_w("mrst_tgt", rsp_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_b("mrst_rdy", req_ready, 1'b1);
    do_lookup("mrst_remiss", 8'd5, 32'h6666_0000, 1'b0, 32'h0000_1014, 32'h6666_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
